shift_vector_gen: RTL and testbench
===================================

Name: shift_vector_gen

Overview:
- Upstream stimulus stage for the 8-bit barrel shifter.
- Generates a programmable-length sequence of (data, shift-control) vectors and presents them on a valid/ready interface.
- Data steps by a fixed increment and control steps by a fixed increment on every accepted vector.
- Its outputs connect directly to the shifter's in/ctrl inputs; the consumer asserts vec_ready when it samples a vector.

Parameters:
- DATA_W, 8, width of data vector (shifter in/out width)
- CTRL_W, 3, width of shift-control vector
- IN_STEP, 64, data increment per accepted vector (mod 2^DATA_W)
- CTRL_STEP, 2, control increment per accepted vector (mod 2^CTRL_W)
- CNT_W, 8, width of vector-count field

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a sequence; sampled only in IDLE
- num_vec  input  CNT_W  number of vectors in the sequence; latched on start
- seed_in  input  DATA_W  first data value; latched on start
- seed_ctrl  input  CTRL_W  first control value; latched on start
- vec_valid  output  1  vec_in/vec_ctrl hold a valid vector
- vec_ready  input  1  consumer accepts the vector this cycle
- vec_in  output  DATA_W  data vector to the shifter
- vec_ctrl  output  CTRL_W  shift amount to the shifter
- vec_last  output  1  current vector is the final one of the sequence
- busy  output  1  sequence in progress (RUN or DONE)
- done  output  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (rst_n=0, async): state=IDLE; vec_valid, vec_in, vec_ctrl, vec_last, busy, done all 0; remaining counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and num_vec!=0: latch values; next cycle state=RUN with vec_in=seed_in, vec_ctrl=seed_ctrl, vec_valid=1, remaining=num_vec. Latency from start to first valid is 1 cycle.
  - start=1 and num_vec=0: go directly to DONE; no vector is issued.
- RUN:
  - Transfer occurs when vec_valid && vec_ready.
  - On each transfer: vec_in += IN_STEP (wraps mod 2^DATA_W), vec_ctrl += CTRL_STEP (wraps mod 2^CTRL_W), remaining -= 1.
  - While vec_valid && !vec_ready, vec_in, vec_ctrl and vec_last are held stable.
  - vec_valid never drops before its transfer.
  - vec_last = (remaining==1), combinational from registered state.
  - A transfer with vec_last=1 moves to DONE and clears vec_valid on the same edge. vec_in/vec_ctrl then hold the post-increment values; they are don't-care to the consumer.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = (state != IDLE).
- start asserted in RUN or DONE is ignored and not queued.
- num_vec=2^CNT_W-1 (maximum) must complete without counter overflow.
- rst_n asserted mid-sequence: immediate abort, all outputs 0. The next start reloads the seeds.

Optional Feature:
- Macro SHIFT_VEC_LFSR_EN.
- Defined: vec_in advances on each transfer by an 8-bit Galois LFSR step instead of +IN_STEP: next = lsb ? (x>>1)^8'hB8 : x>>1. A seed_in of 0 is replaced by 8'h01 at latch time. The vec_ctrl stepping is unchanged. Requires DATA_W=8.
- Undefined: additive stepping only; no LFSR logic is synthesised.

Decomposition:
- Package shift_vec_pkg contains:
  - state enum {IDLE, RUN, DONE}
  - default DATA_W/CTRL_W constants
  - LFSR tap constant 8'hB8
- Sub-module shift_vec_step: combinational next-vector computation (add or LFSR step, control add), instantiated once.

Test Plan:
- Seeds 0/0, num_vec=5, vec_ready=1 constant -> transfers (0,0),(64,2),(128,4),(192,6),(0,0); vec_last only on the 5th; done pulses the cycle after the 5th transfer; busy falls with done.
- Same sequence with vec_ready toggling 1,0,0,1,... -> vec_in/vec_ctrl stable across stall cycles; still exactly 5 transfers with identical values.
- start with num_vec=0 -> vec_valid never rises; done pulses 1 cycle after start; busy high for 1 cycle.
- start pulsed again during RUN (seed_in=8'hFF) -> ignored; sequence values unchanged.
- rst_n low mid-sequence (after 2 transfers) -> all outputs 0 asynchronously; new start with seed_in=8'd10 begins at (10, seed_ctrl).
- With SHIFT_VEC_LFSR_EN, seed_in=8'h01, seed_ctrl=0, num_vec=4 -> vec_in 8'h01, 8'hB8, 8'h5C, 8'h2E; vec_ctrl 0, 2, 4, 6.

Source files
------------

// File: rtl/shift_vec_pkg.sv
// Shared types and constants for the shift-vector generator.
// Optional feature macro: SHIFT_VEC_LFSR_EN (LFSR data stepping).
package shift_vec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEF_DATA_W = 8;
    localparam int          DEF_CTRL_W = 3;
    localparam logic [7:0]  LFSR_TAP   = 8'hB8;

endpackage

// File: rtl/shift_vec_step.sv
// Next-vector computation: data step (add or Galois LFSR) and control add.
// Optional feature macro: SHIFT_VEC_LFSR_EN (LFSR data stepping, DATA_W must be 8).
module shift_vec_step
    import shift_vec_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter int IN_STEP   = 64,
    parameter int CTRL_STEP = 2
) (
    input  logic [DATA_W-1:0] i_cur_in,
    input  logic [CTRL_W-1:0] i_cur_ctrl,
    output logic [DATA_W-1:0] o_nxt_in,
    output logic [CTRL_W-1:0] o_nxt_ctrl
);

    // Data and control advance; both wrap naturally at their widths.
    always_comb begin
`ifdef SHIFT_VEC_LFSR_EN
        o_nxt_in = i_cur_in[0] ? ((i_cur_in >> 1) ^ DATA_W'(LFSR_TAP)) : (i_cur_in >> 1);
`else
        o_nxt_in = i_cur_in + DATA_W'(IN_STEP);
`endif
        o_nxt_ctrl = i_cur_ctrl + CTRL_W'(CTRL_STEP);
    end

endmodule

// File: rtl/shift_vector_gen.sv
// Stimulus generator for the barrel shifter: emits num_vec (data, ctrl)
// vectors on a valid/ready interface, stepping both fields per transfer.
// Optional feature macro: SHIFT_VEC_LFSR_EN (LFSR data stepping, zero seed -> 8'h01).
module shift_vector_gen
    import shift_vec_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter int IN_STEP   = 64,
    parameter int CTRL_STEP = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [DATA_W-1:0] seed_in,
    input  logic [CTRL_W-1:0] seed_ctrl,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [DATA_W-1:0] vec_in,
    output logic [CTRL_W-1:0] vec_ctrl,
    output logic              vec_last,
    output logic              busy,
    output logic              done
);

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_vec_in;
    logic [CTRL_W-1:0]   r_vec_ctrl;
    logic [CNT_W-1:0]    r_remaining;
    logic [DATA_W-1:0]   w_nxt_in;
    logic [CTRL_W-1:0]   w_nxt_ctrl;
    logic [DATA_W-1:0]   w_seed_in;
    logic                w_xfer;
    logic                w_load;

    shift_vec_step #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .IN_STEP   (IN_STEP),
        .CTRL_STEP (CTRL_STEP)
    ) u_step (
        .i_cur_in   (r_vec_in),
        .i_cur_ctrl (r_vec_ctrl),
        .o_nxt_in   (w_nxt_in),
        .o_nxt_ctrl (w_nxt_ctrl)
    );

`ifdef SHIFT_VEC_LFSR_EN
    // An all-zero LFSR state would lock up, so substitute 1.
    assign w_seed_in = (seed_in == '0) ? DATA_W'(1) : seed_in;
`else
    assign w_seed_in = seed_in;
`endif

    // Outputs decode straight from registered state so they are glitch-free.
    assign vec_valid = (r_state == RUN);
    assign vec_last  = (r_remaining == CNT_W'(1));
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign vec_in    = r_vec_in;
    assign vec_ctrl  = r_vec_ctrl;
    assign w_xfer    = vec_valid && vec_ready;
    assign w_load    = (r_state == IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: start only honoured in IDLE; last transfer ends the run.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (num_vec == '0) ? DONE : RUN;
            RUN:     if (w_xfer && vec_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Vector and count datapath: load seeds on start, advance on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_in    <= '0;
            r_vec_ctrl  <= '0;
            r_remaining <= '0;
        end else if (w_load) begin
            r_vec_in    <= w_seed_in;
            r_vec_ctrl  <= seed_ctrl;
            r_remaining <= num_vec;
        end else if (w_xfer) begin
            r_vec_in    <= w_nxt_in;
            r_vec_ctrl  <= w_nxt_ctrl;
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_vector_gen.sv
// Directed bench for shift_vector_gen; honours SHIFT_VEC_LFSR_EN if defined.
module tb_shift_vector_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_vec = '0;
    logic [7:0] seed_in = '0;
    logic [2:0] seed_ctrl = '0;
    logic       vec_ready = 1'b0;
    logic       vec_valid, vec_last, busy, done;
    logic [7:0] vec_in;
    logic [2:0] vec_ctrl;

    int errors = 0;
    int checks = 0;

    shift_vector_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_vec   (num_vec),
        .seed_in   (seed_in),
        .seed_ctrl (seed_ctrl),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_in    (vec_in),
        .vec_ctrl  (vec_ctrl),
        .vec_last  (vec_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [7:0] nv;
        logic [7:0] sd;
        logic [2:0] sc;
        logic       rdy;
        logic       v;
        logic [7:0] din;
        logic [2:0] ctl;
        logic       last;
        logic       bsy;
        logic       dn;
    } row_t;

    row_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic row_t R(logic st, logic [7:0] nv, logic [7:0] sd, logic [2:0] sc,
                               logic rdy, logic v, logic [7:0] din, logic [2:0] ctl,
                               logic last, logic bsy, logic dn);
        row_t r;
        r.st = st; r.nv = nv; r.sd = sd; r.sc = sc; r.rdy = rdy;
        r.v = v; r.din = din; r.ctl = ctl; r.last = last; r.bsy = bsy; r.dn = dn;
        return r;
    endfunction

    // Each row: inputs applied this cycle, outputs expected this cycle. Entered at negedge.
    task automatic run_rows(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; num_vec = tbl[i].nv; seed_in = tbl[i].sd;
            seed_ctrl = tbl[i].sc; vec_ready = tbl[i].rdy;
            #1;
            chk($sformatf("%s r%0d flags(v,last,busy,done)", tag, i),
                {28'd0, vec_valid, vec_last, busy, done},
                {28'd0, tbl[i].v, tbl[i].last, tbl[i].bsy, tbl[i].dn});
            if (tbl[i].v)
                chk($sformatf("%s r%0d data(in,ctrl)", tag, i),
                    {21'd0, vec_in, vec_ctrl}, {21'd0, tbl[i].din, tbl[i].ctl});
            @(negedge clk);
        end
        start = 1'b0; vec_ready = 1'b0;
        tbl.delete();
    endtask

    // Seeds 0/0, five vectors, ready held high; optional ignored restarts mid-run.
    task automatic push_seq5(input bit restart);
        tbl.push_back(R(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd0,   3'd0, 0, 1, 0));
        tbl.push_back(R(restart, 1, 8'hFF, 7, 1, 1, 8'd64,  3'd2, 0, 1, 0));
        tbl.push_back(R(restart, 1, 8'hFF, 7, 1, 1, 8'd128, 3'd4, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd192, 3'd6, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd0,   3'd0, 1, 1, 0));
        tbl.push_back(R(restart, 1, 8'hFF, 7, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        int xfers, badlast, cyc;
        bit saw_done;
        logic [7:0] fin_in;
        logic [2:0] fin_ctrl;

        // Reset state.
        #3;
        chk("reset flags", {28'd0, vec_valid, vec_last, busy, done}, 32'd0);
        chk("reset data", {21'd0, vec_in, vec_ctrl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef SHIFT_VEC_LFSR_EN
        push_seq5(1'b0);
        run_rows("seq5");

        // Ready pattern 1,0,0 repeating: stalled vectors must hold.
        tbl.push_back(R(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd0,   3'd0, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 1, 8'd64,  3'd2, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 1, 8'd64,  3'd2, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd64,  3'd2, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 1, 8'd128, 3'd4, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 1, 8'd128, 3'd4, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd128, 3'd4, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 1, 8'd192, 3'd6, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 1, 8'd192, 3'd6, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd192, 3'd6, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 1, 8'd0,   3'd0, 1, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 1, 8'd0,   3'd0, 1, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd0,   3'd0, 1, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_rows("stall");

        // Restart attempts during RUN/DONE are ignored.
        push_seq5(1'b1);
        run_rows("restart");
`else
        // LFSR stepping from seed 1, then zero-seed substitution.
        tbl.push_back(R(1, 4, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'h01, 3'd0, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'hB8, 3'd2, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'h5C, 3'd4, 0, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'h2E, 3'd6, 1, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(R(1, 1, 8'h00, 5, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'h01, 3'd5, 1, 1, 0));
        tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_rows("lfsr");
`endif

        // num_vec=0: straight to DONE, no vector.
        tbl.push_back(R(1, 0, 8'h33, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(R(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        run_rows("zero");

        // Async reset after two transfers, then reload from new seeds.
        start = 1'b1; num_vec = 8'd5; seed_in = 8'd0; seed_ctrl = 3'd0;
        @(negedge clk);
        start = 1'b0; vec_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vec_ready = 1'b0;
        #1;
        chk("prereset data", {21'd0, vec_in, vec_ctrl},
`ifdef SHIFT_VEC_LFSR_EN
            {21'd0, 8'h5C, 3'd4});
`else
            {21'd0, 8'd128, 3'd4});
`endif
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset flags", {28'd0, vec_valid, vec_last, busy, done}, 32'd0);
        chk("midreset data", {21'd0, vec_in, vec_ctrl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tbl.push_back(R(1, 2, 8'd10, 3, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd10, 3'd3, 0, 1, 0));
`ifdef SHIFT_VEC_LFSR_EN
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'h05, 3'd5, 1, 1, 0));
`else
        tbl.push_back(R(0, 0, 0, 0, 1, 1, 8'd74, 3'd5, 1, 1, 0));
`endif
        tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_rows("reload");

        // Maximum count: 255 transfers, vec_last only on the final one.
        start = 1'b1; num_vec = 8'd255; seed_in = 8'd0; seed_ctrl = 3'd0;
        @(negedge clk);
        start = 1'b0; vec_ready = 1'b1;
        xfers = 0; badlast = 0; saw_done = 1'b0; fin_in = '0; fin_ctrl = '0;
        for (cyc = 0; cyc < 400; cyc++) begin
            #1;
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            if (vec_valid) begin
                xfers++;
                if (vec_last != (xfers == 255)) badlast++;
                if (xfers == 255) begin
                    fin_in = vec_in;
                    fin_ctrl = vec_ctrl;
                end
            end
            @(negedge clk);
        end
        vec_ready = 1'b0;
        chk("max done seen", {31'd0, saw_done}, 32'd1);
        chk("max transfers", xfers, 32'd255);
        chk("max last placement", badlast, 32'd0);
`ifndef SHIFT_VEC_LFSR_EN
        chk("max final data", {21'd0, fin_in, fin_ctrl}, {21'd0, 8'd128, 3'd4});
`endif
        @(negedge clk);
        #1;
        chk("max back idle", {28'd0, vec_valid, vec_last, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
